uart_tx_fifo_drain: RTL and testbench
=====================================

UART_TX_FIFO_DRAIN -- requirements
Module: uart_tx_fifo_drain

Interface
REQ-001 Parameter DATA_WIDTH, 8, frame data bits; equals the attached FIFO data width.
REQ-002 Parameter CLKS_PER_BIT, 16, Clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY_EN, 0, 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, 1, number of stop bits; legal values 1 or 2.
REQ-006 Clk  input  1  single clock; the same clock as the FIFO read-port clock RClk.
REQ-007 Rst_n_in  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-008 Enable_in  input  1  permits the start of new frames.
REQ-009 Fifo_Data_in  input  DATA_WIDTH  FIFO read data; valid in the cycle after a read strobe.
REQ-010 Fifo_Empty_in  input  1  FIFO empty flag.
REQ-011 Fifo_ReadEn_out  output  1  FIFO read strobe; a single-cycle pulse per frame.
REQ-012 Tx_out  output  1  serial line; idles high.
REQ-013 Busy_out  output  1  high from the read strobe through the last stop-bit cycle.
REQ-014 Frame_done_out  output  1  single-cycle pulse after the last stop bit.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH, START, DATA, PARITY and STOP; Tx_out, Busy_out and Frame_done_out SHALL all be registered.
REQ-016 IDLE: when Enable_in=1 and Fifo_Empty_in=0, the block SHALL drive Fifo_ReadEn_out=1 combinationally for that cycle and move to FETCH; otherwise it SHALL stay in IDLE.
REQ-017 Fifo_ReadEn_out SHALL never be 1 while Fifo_Empty_in=1 or in any state other than IDLE.
REQ-018 FETCH (one cycle): the block SHALL latch Fifo_Data_in into the shift register, clear the bit counter and the baud counter, and move to START.
REQ-019 START, DATA, PARITY and STOP bits SHALL each last exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and then wraps.
REQ-020 START: Tx_out SHALL be 0.
REQ-021 DATA: the block SHALL send DATA_WIDTH bits LSB first, with a right shift at each baud wrap; after the last bit it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 PARITY: Tx_out SHALL equal the XOR of the latched byte, inverted when PARITY_ODD=1.
REQ-023 STOP: Tx_out SHALL be 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 At the end of STOP the block SHALL pulse Frame_done_out for one cycle and return to IDLE.
REQ-025 Back-to-back frames: with data available, the line SHALL be high for exactly 2 cycles (IDLE and FETCH) between the last stop-bit cycle and the next start bit.
REQ-026 Dropping Enable_in mid-frame SHALL NOT abort the frame; it only blocks the next read in IDLE.
REQ-027 A Fifo_Empty_in change during a frame SHALL have no effect until IDLE.
REQ-028 Tx_out SHALL lag the state register by one cycle (registered output); every bit period SHALL still measure exactly CLKS_PER_BIT cycles on the pin.

Reset
REQ-029 While Rst_n_in=0 at a Clk edge, the block SHALL set state=IDLE, Tx_out=1, Busy_out=0, Frame_done_out=0, and clear the counters and shift register; Fifo_ReadEn_out SHALL be 0 while Rst_n_in=0.
REQ-030 A reset mid-frame SHALL truncate the frame with Tx_out=1 from the next edge onward; the byte already read SHALL be discarded and SHALL NOT be re-requested.

Verification
REQ-031 CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, Enable_in=1 -> exactly one ReadEn pulse; Tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one Frame_done pulse; 40 cycles from start-bit edge to end of stop bit.
REQ-032 PARITY_EN=1, PARITY_ODD=1, byte 0x07 -> parity bit 0; PARITY_ODD=0 -> parity bit 1; STOP_BITS=2 -> 8 stop cycles at CLKS_PER_BIT=4.
REQ-033 FIFO holds 0x00 then 0xFF -> two frames, line high exactly 2 cycles between them, two ReadEn pulses, Fifo_Empty_in=1 afterwards -> no further ReadEn, Tx_out stays 1.
REQ-034 Fifo_Empty_in=1 for 100 cycles with Enable_in=1 -> Fifo_ReadEn_out never 1, Busy_out=0, Tx_out=1.
REQ-035 Rst_n_in=0 for one cycle during DATA bit 3 -> Tx_out=1 and Busy_out=0 on the next edge, no Frame_done pulse; the next FIFO entry is sent normally after release.
REQ-036 Enable_in dropped during START of 0x3C -> the full frame completes; no new ReadEn until Enable_in=1 again.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a FIFO read port: one read strobe per frame,
// start/data/optional parity/stop bits, all line-side outputs registered.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n_in,
  input  logic                  Enable_in,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  Fifo_Empty_in,
  output logic                  Fifo_ReadEn_out,
  output logic                  Tx_out,
  output logic                  Busy_out,
  output logic                  Frame_done_out
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [BW-1:0]         baud;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par;
  logic                  baud_wrap;
  logic                  tx_nxt;
  logic                  frame_end;

  assign baud_wrap = (baud == BAUD_LAST);

  always_comb begin
    state_nxt       = state;
    Fifo_ReadEn_out = 1'b0;
    tx_nxt          = 1'b1;
    frame_end       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Rst_n_in && Enable_in && !Fifo_Empty_in) begin
          Fifo_ReadEn_out = 1'b1;
          state_nxt       = FETCH;
        end
      end
      FETCH: state_nxt = START;
      START: begin
        tx_nxt = 1'b0;
        if (baud_wrap) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (baud_wrap && bit_cnt == DATA_LAST)
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx_nxt = par;
        if (baud_wrap) state_nxt = STOP;
      end
      STOP: begin
        if (baud_wrap && bit_cnt == STOP_LAST) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Line outputs are driven from the current state, so the pin lags the FSM
  // by exactly one cycle while every bit keeps its full width.
  always_ff @(posedge Clk) begin
    if (!Rst_n_in) begin
      Tx_out         <= 1'b1;
      Busy_out       <= 1'b0;
      Frame_done_out <= 1'b0;
    end else begin
      Tx_out         <= tx_nxt;
      Busy_out       <= Fifo_ReadEn_out || (state != IDLE);
      Frame_done_out <= frame_end;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n_in) begin
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          shreg   <= Fifo_Data_in;
          par     <= (^Fifo_Data_in) ^ (PARITY_ODD != 0);
          baud    <= '0;
          bit_cnt <= '0;
        end
        START, PARITY: begin
          baud <= baud_wrap ? '0 : baud + BW'(1);
        end
        DATA: begin
          baud <= baud_wrap ? '0 : baud + BW'(1);
          if (baud_wrap) begin
            shreg   <= shreg >> 1;
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + CW'(1);
          end
        end
        STOP: begin
          baud <= baud_wrap ? '0 : baud + BW'(1);
          if (baud_wrap) bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: three instances (plain, odd parity/2 stop, even parity/2 stop)
// fed from queue FIFO models; per-instance monitors compare line waveforms.
module tb_uart_tx_fifo_drain;
  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          b2b;
    bit          abort;
  } frame_t;

  logic       Clk;
  logic       rst_n;
  logic       en;
  logic [7:0] fdata [3];
  logic       empty [3];
  logic       rd    [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  frame_t     exp_q  [3][$];
  logic [7:0] fifo_q [3][$];
  int         rd_cnt [3] = '{default: 0};
  int         viol   = 0;
  int         passed = 0;
  int         total  = 0;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                       .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .Clk(Clk), .Rst_n_in(rst_n), .Enable_in(en), .Fifo_Data_in(fdata[0]),
    .Fifo_Empty_in(empty[0]), .Fifo_ReadEn_out(rd[0]), .Tx_out(tx[0]),
    .Busy_out(busy[0]), .Frame_done_out(done[0]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
    .Clk(Clk), .Rst_n_in(rst_n), .Enable_in(en), .Fifo_Data_in(fdata[1]),
    .Fifo_Empty_in(empty[1]), .Fifo_ReadEn_out(rd[1]), .Tx_out(tx[1]),
    .Busy_out(busy[1]), .Frame_done_out(done[1]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .Clk(Clk), .Rst_n_in(rst_n), .Enable_in(en), .Fifo_Data_in(fdata[2]),
    .Fifo_Empty_in(empty[2]), .Fifo_ReadEn_out(rd[2]), .Tx_out(tx[2]),
    .Busy_out(busy[2]), .Frame_done_out(done[2]));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
  endtask

  // FIFO model: read data appears the cycle after the strobe.
  initial begin
    logic rs [3];
    for (int g = 0; g < 3; g++) begin
      empty[g] = 1'b1;
      fdata[g] = '0;
    end
    forever begin
      @(negedge Clk);
      for (int g = 0; g < 3; g++) rs[g] = rd[g];
      @(posedge Clk);
      #1;
      for (int g = 0; g < 3; g++)
        if (rs[g] === 1'b1 && fifo_q[g].size() != 0) fdata[g] = fifo_q[g].pop_front();
      #1;
      for (int g = 0; g < 3; g++) empty[g] = (fifo_q[g].size() == 0);
    end
  end

  always @(negedge Clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd[g] === 1'b1) rd_cnt[g] <= rd_cnt[g] + 1;
      if (rd[g] === 1'b1 && empty[g] === 1'b1) viol <= viol + 1;
    end
  end

  task automatic mon(input int g);
    logic        prev = 1'b1;
    int          idle = 0;
    frame_t      f;
    logic [15:0] got;
    bit          bad, ab;
    int          nd;
    forever begin
      @(negedge Clk);
      if (rst_n !== 1'b1) begin
        prev = 1'b1;
        idle = 0;
      end else if (!(prev === 1'b1 && tx[g] === 1'b0)) begin
        if (tx[g] === 1'b1) idle++;
        prev = tx[g];
      end else if (exp_q[g].size() == 0) begin
        chk(1'b0, "unexpected_frame", g, 0);
        prev = 1'b0;
      end else begin
        f = exp_q[g].pop_front();
        if (f.b2b) chk(idle == 2, "b2b_gap", idle, 2);
        got = '0; bad = 0; ab = 0; nd = 0;
        for (int b = 0; b < f.n && !ab; b++)
          for (int c = 0; c < CPB && !ab; c++) begin
            if (b != 0 || c != 0) @(negedge Clk);
            if (rst_n !== 1'b1) ab = 1;
            else begin
              if (done[g] === 1'b1) nd++;
              if (c == 0) got[b] = tx[g];
              else if (tx[g] !== got[b]) bad = 1;
            end
          end
        if (ab) begin
          chk(f.abort && nd == 0, "abort", nd, 0);
          while (rst_n !== 1'b1) @(negedge Clk);
          prev = 1'b1;
          idle = 0;
        end else begin
          @(negedge Clk);
          if (done[g] === 1'b1) nd++;
          chk(!f.abort && !bad && got == f.bits, "frame", int'(got), int'(f.bits));
          chk(nd == 1, "frame_done", nd, 1);
          prev = tx[g];
          idle = (tx[g] === 1'b1) ? 1 : 0;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic send(input int g, input logic [7:0] d, input logic [15:0] bits,
                      input int n, input bit b2b, input bit abort);
    frame_t f;
    f.bits = bits; f.n = n; f.b2b = b2b; f.abort = abort;
    exp_q[g].push_back(f);
    fifo_q[g].push_back(d);
  endtask

  task automatic drain();
    int t = 0;
    bit quiet = 0;
    while (!quiet && t < 3000) begin
      @(posedge Clk); #1;
      t++;
      quiet = 1;
      for (int g = 0; g < 3; g++)
        if (exp_q[g].size() != 0 || fifo_q[g].size() != 0 || busy[g] !== 1'b0) quiet = 0;
    end
    chk(quiet, "drain", t, 3000);
    repeat (10) @(posedge Clk);
    #1;
  endtask

  task automatic wait_fall(input int g);
    int t = 0;
    while (tx[g] !== 1'b0 && t < 300) begin
      @(posedge Clk); #1;
      t++;
    end
    chk(tx[g] === 1'b0, "start_wait", t, 300);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int g = 0; g < 3; g++) begin
      chk(tx[g] === 1'b1, "rst_tx", int'(tx[g]), 1);
      chk(busy[g] === 1'b0, "rst_busy", int'(busy[g]), 0);
      chk(done[g] === 1'b0 && rd[g] === 1'b0, "rst_done_rd", int'(done[g]), 0);
    end
    @(posedge Clk); #1;
    rst_n = 1'b1;
    en    = 1'b1;

    // single 0xA5 frame; parity variants of 0x07 then 0x03 back to back
    send(0, 8'hA5, 16'h034A, 10, 0, 0);
    send(1, 8'h07, 16'h0C0E, 12, 0, 0);
    send(1, 8'h03, 16'h0E06, 12, 1, 0);
    send(2, 8'h07, 16'h0E0E, 12, 0, 0);
    send(2, 8'h03, 16'h0C06, 12, 1, 0);
    drain();
    chk(rd_cnt[0] == 1, "rd_cnt_a5", rd_cnt[0], 1);

    // 0x00 then 0xFF back to back, then empty FIFO with enable held
    send(0, 8'h00, 16'h0200, 10, 0, 0);
    send(0, 8'hFF, 16'h03FE, 10, 1, 0);
    drain();
    chk(rd_cnt[0] == 3, "rd_cnt_b2b", rd_cnt[0], 3);
    bad = 0;
    repeat (100) begin
      @(negedge Clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd[0] !== 1'b0) bad++;
    end
    chk(bad == 0, "idle_hold", bad, 0);
    chk(rd_cnt[0] == 3, "rd_cnt_idle", rd_cnt[0], 3);

    // reset during data bit 3 of 0x5A; 0x81 must follow normally
    send(0, 8'h5A, 16'h0000, 10, 0, 1);
    send(0, 8'h81, 16'h0302, 10, 0, 0);
    wait_fall(0);
    repeat (17) @(posedge Clk);
    #1;
    rst_n = 1'b0;
    @(posedge Clk); #1;
    chk(tx[0] === 1'b1, "rst_mid_tx", int'(tx[0]), 1);
    chk(busy[0] === 1'b0, "rst_mid_busy", int'(busy[0]), 0);
    rst_n = 1'b1;
    drain();
    chk(rd_cnt[0] == 5, "rd_cnt_rst", rd_cnt[0], 5);

    // enable dropped during the start bit of 0x3C
    send(0, 8'h3C, 16'h0278, 10, 0, 0);
    send(0, 8'h11, 16'h0222, 10, 0, 0);
    wait_fall(0);
    en = 1'b0;
    repeat (80) @(posedge Clk);
    #1;
    chk(rd_cnt[0] == 6, "rd_cnt_en_low", rd_cnt[0], 6);
    chk(exp_q[0].size() == 1, "pending_frames", exp_q[0].size(), 1);
    en = 1'b1;
    drain();
    chk(rd_cnt[0] == 7, "rd_cnt_en_high", rd_cnt[0], 7);
    chk(rd_cnt[1] == 2, "rd_cnt_odd", rd_cnt[1], 2);
    chk(rd_cnt[2] == 2, "rd_cnt_even", rd_cnt[2], 2);
    chk(viol == 0, "rd_while_empty", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
